// File: rtl/log_input_framer_pkg.sv
// Shared widths for the log (highest-set-bit) encoder path and its input framer.
// The encoder imports the same package, so framer word width and encoder
// inVector width cannot drift apart.
package log_input_framer_pkg;

  // Encoder input vector width (framer word width).
  localparam int LOG_BIN_SIZE  = 8;
  // Encoder output width; also the framer bit-counter width.
  localparam int LOG_BOUT_SIZE = 3;

  // Output FIFO depth and the width of its occupancy counter (0..2).
  localparam int FIFO_DEPTH   = 2;
  localparam int FIFO_CNT_W   = 2;

endpackage

// File: rtl/log_input_framer_if.sv
// Bit-stream input and word-stream output of the log input framer.
// Ports: bit_in/bit_valid/frame_start (serial side), out_vector/out_valid/out_ready (word side).
// modport master = the framer (produces words); modport slave = its environment.
interface log_input_framer_if
  import log_input_framer_pkg::*;
#(
  parameter int BIN_SIZE = LOG_BIN_SIZE
) ();

  logic                bit_in;
  logic                bit_valid;
  logic                frame_start;
  logic [BIN_SIZE-1:0] out_vector;
  logic                out_valid;
  logic                out_ready;

  modport master (
    input  bit_in, bit_valid, frame_start, out_ready,
    output out_vector, out_valid
  );

  modport slave (
    output bit_in, bit_valid, frame_start, out_ready,
    input  out_vector, out_valid
  );

endinterface

// File: rtl/log_input_framer_fifo2.sv
// log_fifo2: 2-entry register FIFO; push/pop same cycle allowed even when full.
// Ports: clk, reset (async, active-high), push/din, pop, full/empty, head (0 when empty).
// Latency: a pushed word is at the head one cycle later when the FIFO was empty.
module log_fifo2
  import log_input_framer_pkg::*;
#(
  parameter int WIDTH = LOG_BIN_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]      ent0_q, ent0_d;   // head entry
  logic [WIDTH-1:0]      ent1_q, ent1_d;
  logic                  do_pop, do_push;

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    do_pop  = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves the same cycle.
    do_push = push && ((count_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

    if (do_pop && do_push) begin
      if (count_q == FIFO_CNT_W'(1)) begin
        ent0_d = din;
      end else begin
        ent0_d = ent1_q;
        ent1_d = din;
      end
    end else if (do_pop) begin
      ent0_d  = ent1_q;
      ent1_d  = '0;
      count_d = count_q - FIFO_CNT_W'(1);
    end else if (do_push) begin
      if (count_q == '0) ent0_d = din;
      else               ent1_d = din;
      count_d = count_q + FIFO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  // Stale entry contents are masked so an empty FIFO always shows zero.
  assign head  = empty ? '0 : ent0_q;

endmodule

// File: rtl/log_input_framer.sv
// Serial-to-word framer feeding the log encoder: LSB-first words, all-zero words dropped.
// Ports: clk, reset (async, active-high), bus (log_input_framer_if.master), zero_drop, overflow, busy.
// Latency 1 cycle from last bit to out_valid; 2-word buffer; overflow is sticky.
module log_input_framer
  import log_input_framer_pkg::*;
#(
  parameter int BIN_SIZE = LOG_BIN_SIZE,
  parameter int CNT_SIZE = LOG_BOUT_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  log_input_framer_if.master     bus,
  output logic                   zero_drop,
  output logic                   overflow,
  output logic                   busy
);

  localparam logic [CNT_SIZE-1:0] LAST_BIT = CNT_SIZE'(BIN_SIZE - 1);

  logic [CNT_SIZE-1:0] cnt_q, cnt_d;
  logic [BIN_SIZE-1:0] shift_q, shift_d;
  logic                zero_drop_q, zero_drop_d;
  logic                overflow_q, overflow_d;

  logic [BIN_SIZE-1:0] word;
  logic                word_done, word_nz;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [BIN_SIZE-1:0] fifo_head;

  // Current word including this cycle's bit, so completion needs no extra cycle.
  always_comb begin
    word        = shift_q;
    word[cnt_q] = bus.bit_in;
  end

  // frame_start pre-empts completion: a word ending on a restart cycle is discarded.
  assign word_done = bus.bit_valid && !bus.frame_start && (cnt_q == LAST_BIT);
  assign word_nz   = |word;
  assign fifo_pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (bus.frame_start) begin
      // The restart bit itself is kept as bit 0 of the new word.
      cnt_d   = bus.bit_valid ? CNT_SIZE'(1) : '0;
      shift_d = '0;
      if (bus.bit_valid) shift_d[0] = bus.bit_in;
    end else if (bus.bit_valid) begin
      if (cnt_q == LAST_BIT) begin
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        cnt_d   = cnt_q + CNT_SIZE'(1);
        shift_d = word;
      end
    end
  end

  always_comb begin
    zero_drop_d = word_done && !word_nz;
    // Lost only when full with no pop; a simultaneous pop makes room.
    overflow_d  = overflow_q || (word_done && word_nz && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      zero_drop_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      zero_drop_q <= zero_drop_d;
      overflow_q  <= overflow_d;
    end
  end

  log_fifo2 #(.WIDTH(BIN_SIZE)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (word_done && word_nz),
    .din   (word),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign bus.out_valid  = !fifo_empty;
  assign bus.out_vector = fifo_head;
  assign zero_drop      = zero_drop_q;
  assign overflow       = overflow_q;
  assign busy           = (cnt_q != '0);

endmodule

// File: tb/tb_log_input_framer.sv
module tb_log_input_framer;
  import log_input_framer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic zero_drop, overflow, busy;

  log_input_framer_if #(.BIN_SIZE(8)) bus ();

  log_input_framer #(.BIN_SIZE(8), .CNT_SIZE(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .zero_drop (zero_drop),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compares every accepted word against the scoreboard, and checks
  // the non-zero invariant and stability while stalled.
  logic       stall_prev = 1'b0;
  logic [7:0] vec_prev   = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) chk("nonzero_invariant", 32'(bus.out_vector != 8'h00), 32'd1);
      if (stall_prev && bus.out_valid) chk("stall_stable", 32'(bus.out_vector), 32'(vec_prev));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(bus.out_vector), 32'hFFFF_FFFF);
        else chk("word", 32'(bus.out_vector), 32'(exp_q.pop_front()));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      vec_prev   = bus.out_vector;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
  endtask

  task automatic idle(input int n);
    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;
    bus.frame_start = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    bus.bit_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    chk({tag, "_out_vector"}, 32'(bus.out_vector), 32'd0);
    chk({tag, "_zero_drop"},  32'(zero_drop),      32'd0);
    chk({tag, "_overflow"},   32'(overflow),       32'd0);
    chk({tag, "_busy"},       32'(busy),           32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w;
    reset           = 1'b1;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.out_ready   = 1'b1;
    #3;
    check_all_zero("init");
    tick();
    reset = 1'b0;
    tick();

    // 1: 0,0,0,1,0,0,0,0 -> 8'h08 visible the cycle after the last bit.
    exp_q.push_back(8'h08);
    send_bit(0); send_bit(0); send_bit(0);
    chk("t1_busy_mid", 32'(busy), 32'd1);
    send_bit(1); send_bit(0); send_bit(0); send_bit(0); send_bit(0);
    bus.bit_valid = 1'b0;
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_vector", 32'(bus.out_vector), 32'h08);
    tick();
    chk("t1_valid_one_cycle", 32'(bus.out_valid), 32'd0);

    // 2: all-zero word is dropped with a one-cycle zero_drop pulse.
    send_word(8'h00);
    chk("t2_zero_drop", 32'(zero_drop), 32'd1);
    chk("t2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);
    tick();
    chk("t2_zero_drop_end", 32'(zero_drop), 32'd0);

    // 3: stalled consumer, third word overflows and is lost.
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_word(8'h01);
    chk("t3_overflow_pre", 32'(overflow), 32'd0);
    send_word(8'h80);
    send_word(8'h05);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_head", 32'(bus.out_vector), 32'h01);
    idle(2);
    bus.out_ready = 1'b1;
    idle(4);
    chk("t3_drained", 32'(bus.out_valid), 32'd0);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    do_reset();

    // 4: full FIFO, pop in the same cycle the third word completes.
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h05);
    send_word(8'h01);
    send_word(8'h80);
    w = 8'h05;
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    bus.out_ready = 1'b1;
    send_bit(w[7]);
    bus.bit_valid = 1'b0;
    chk("t4_overflow", 32'(overflow), 32'd0);
    chk("t4_head", 32'(bus.out_vector), 32'h80);
    idle(4);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_overflow_end", 32'(overflow), 32'd0);

    // 5: frame_start with a bit discards the 5-bit partial word.
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    bus.frame_start = 1'b1;
    exp_q.push_back(8'h01);
    send_bit(1);
    bus.frame_start = 1'b0;
    chk("t5_busy_restart", 32'(busy), 32'd1);
    chk("t5_no_word_yet", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 7; i++) send_bit(0);
    bus.bit_valid = 1'b0;
    chk("t5_vector", 32'(bus.out_vector), 32'h01);
    idle(3);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: asynchronous reset mid-word with one word buffered.
    bus.out_ready = 1'b0;
    send_word(8'h03);
    send_bit(1); send_bit(1); send_bit(0); send_bit(1);
    chk("t6_valid_before", 32'(bus.out_valid), 32'd1);
    chk("t6_busy_before", 32'(busy), 32'd1);
    bus.bit_valid = 1'b0;
    do_reset();
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h40);
    send_word(8'h40);
    chk("t6_fresh_vector", 32'(bus.out_vector), 32'h40);
    idle(3);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
